dct_mac_sequencer: RTL and testbench

- Sequences one shared multiply-accumulate unit (macu) inside a dct_unit through a full 8x8 DCT row pass.
- Generates the sample and coefficient select, and the accumulator clear/enable, for each output coefficient.
- Waits out the MAC pipeline latency, then captures the accumulator result and presents it downstream with a valid/ready handshake.
- Sits between dct_block control (start/done) and the macu datapath.

---
 rtl/dct_mac_sequencer.sv | 174 +++++++++++++++++
 tb/tb_dct_mac_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer: steps a shared multiply-accumulate unit through one DCT
// row pass. For each output coefficient it issues TAPS accumulate cycles,
// waits out the MAC pipeline latency, captures the accumulator and offers it
// downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   ena             global clock enable (low freezes all state)
//   start           begin a pass (accepted only when idle)
//   busy, done      pass in progress; one-cycle pulse after the last result
//   sample_sel      row-buffer sample index (current tap)
//   coef_sel        coefficient ROM address {out_idx, tap}
//   mac_clr, mac_en accumulator clear / accumulate strobes (combinational)
//   mac_result      accumulator output of the MAC unit
//   res_data/res_idx/res_valid/res_ready  result handshake
//   stall_cnt       (only with DCT_MAC_SEQ_STALL_CNT_EN) saturating count of
//                   enabled cycles spent with res_valid && !res_ready
//
// Optional feature macro: DCT_MAC_SEQ_STALL_CNT_EN
module dct_mac_sequencer #(
    parameter int unsigned TAPS    = 8,
    parameter int unsigned OUTS    = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned ACC_W   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     sample_sel,
    output logic [2*IDX_W-1:0]   coef_sel,
    output logic                 mac_clr,
    output logic                 mac_en,
    input  logic [ACC_W-1:0]     mac_result,
    output logic [ACC_W-1:0]     res_data,
    output logic [IDX_W-1:0]     res_idx,
    output logic                 res_valid,
    input  logic                 res_ready
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int unsigned LAT_W   = 3;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   tap_q, tap_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic               res_valid_q, res_valid_d;
    logic               done_q, done_d;
    logic               xfer;
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

    // State register; done is a pulse so it is refreshed every cycle, which
    // only ever clears it while ena is low (done_d needs ena to be set).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            out_idx_q   <= '0;
            lat_cnt_q   <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            done_q <= done_d;
            if (ena) begin
                state_q     <= state_d;
                tap_q       <= tap_d;
                out_idx_q   <= out_idx_d;
                lat_cnt_q   <= lat_cnt_d;
                res_data_q  <= res_data_d;
                res_idx_q   <= res_idx_d;
                res_valid_q <= res_valid_d;
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
                stall_cnt_q <= stall_cnt_d;
`endif
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        out_idx_d   = out_idx_q;
        lat_cnt_d   = lat_cnt_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
        xfer        = res_valid_q && res_ready && ena;
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
        stall_cnt_d = stall_cnt_q;
        if (res_valid_q && !res_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    tap_d     = '0;
                    out_idx_d = '0;
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            ACCUM: begin
                // TAPS is a power of two, so the increment wraps to 0 by itself
                tap_d = tap_q + IDX_W'(1);
                if (tap_q == IDX_W'(TAPS - 1)) begin
                    state_d   = DRAIN;
                    lat_cnt_d = LAT_W'(MAC_LAT - 1);
                end
            end
            DRAIN: begin
                if (lat_cnt_q == '0) begin
                    res_data_d  = mac_result;
                    res_idx_d   = out_idx_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            HOLD: begin
                if (xfer) begin
                    res_valid_d = 1'b0;
                    if (out_idx_q == IDX_W'(OUTS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        out_idx_d = out_idx_q + IDX_W'(1);
                        state_d   = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MAC strobes are gated by ena without a register stage
    assign mac_en     = (state_q == ACCUM) && ena;
    assign mac_clr    = mac_en && (tap_q == '0);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign sample_sel = tap_q;
    assign coef_sel   = {out_idx_q, tap_q};
    assign res_data   = res_data_q;
    assign res_idx    = res_idx_q;
    assign res_valid  = res_valid_q;
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Bench for dct_mac_sequencer: a behavioural MAC unit and row/coefficient
// model supply mac_result and the expected coefficients; a negedge compare
// process checks every result, done pulse and strobe rule, while directed
// passes pin latency, backpressure, freeze, reset and start-while-busy.
module tb_dct_mac_sequencer;

    localparam int unsigned TAPS = 8, OUTS = 8, IDX_W = 3, MAC_LAT = 2, ACC_W = 24;
    localparam int unsigned T2 = 4, I2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0, ena = 1'b1, start = 1'b0, res_ready = 1'b1, start2 = 1'b0;

    logic               busy, done, mac_clr, mac_en, res_valid;
    logic [IDX_W-1:0]   sample_sel, res_idx;
    logic [2*IDX_W-1:0] coef_sel;
    logic [ACC_W-1:0]   mac_result, res_data;

    logic               busy2, done2, mac_clr2, mac_en2, res_valid2;
    logic [I2-1:0]      sample_sel2, res_idx2;
    logic [2*I2-1:0]    coef_sel2;
    logic [ACC_W-1:0]   mac_result2, res_data2;
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
    logic [15:0]        stall_cnt, stall_cnt2;
`endif

    dct_mac_sequencer #(.TAPS(TAPS), .OUTS(OUTS), .IDX_W(IDX_W), .MAC_LAT(MAC_LAT), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .busy(busy), .done(done),
        .sample_sel(sample_sel), .coef_sel(coef_sel), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_result(mac_result), .res_data(res_data), .res_idx(res_idx),
        .res_valid(res_valid), .res_ready(res_ready)
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    dct_mac_sequencer #(.TAPS(T2), .OUTS(T2), .IDX_W(I2), .MAC_LAT(1), .ACC_W(ACC_W)) u_dut4 (
        .clk(clk), .rst(rst), .ena(ena), .start(start2), .busy(busy2), .done(done2),
        .sample_sel(sample_sel2), .coef_sel(coef_sel2), .mac_clr(mac_clr2), .mac_en(mac_en2),
        .mac_result(mac_result2), .res_data(res_data2), .res_idx(res_idx2),
        .res_valid(res_valid2), .res_ready(res_ready)
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference data and MAC unit model ----------------
    logic [7:0]       sample [TAPS];
    logic [7:0]       coef [TAPS*OUTS];
    logic [ACC_W-1:0] exp_data [OUTS];
    logic [7:0]       sample2 [T2];
    logic [7:0]       coef2 [T2*T2];
    logic [ACC_W-1:0] exp2 [T2];

    logic [ACC_W-1:0] acc = '0, pipe = '0, acc2 = '0;
    logic [ACC_W-1:0] prod, prod2;
    assign prod  = ACC_W'(sample[sample_sel]) * ACC_W'(coef[coef_sel]);
    assign prod2 = ACC_W'(sample2[sample_sel2]) * ACC_W'(coef2[coef_sel2]);

    // Accumulator stage plus MAC_LAT-1 extra pipeline stages
    always @(posedge clk) begin
        if (mac_en)  acc  <= mac_clr ? prod : acc + prod;
        if (ena)     pipe <= acc;
        if (mac_en2) acc2 <= mac_clr2 ? prod2 : acc2 + prod2;
    end
    assign mac_result  = pipe;
    assign mac_result2 = acc2;

    task automatic new_data(input bit det);
        longint s;
        for (int t = 0; t < TAPS; t++) sample[t] = det ? 8'(t + 1) : 8'($urandom);
        for (int i = 0; i < TAPS*OUTS; i++) coef[i] = det ? 8'(i / TAPS) : 8'($urandom);
        for (int k = 0; k < OUTS; k++) begin
            s = 0;
            for (int t = 0; t < TAPS; t++) s += longint'(sample[t]) * longint'(coef[k*TAPS + t]);
            exp_data[k] = ACC_W'(s);
        end
    endtask

    task automatic new_data2();
        longint s;
        for (int t = 0; t < T2; t++) sample2[t] = 8'(t + 1);
        for (int i = 0; i < T2*T2; i++) coef2[i] = 8'(i / T2 + 1);
        for (int k = 0; k < T2; k++) begin
            s = 0;
            for (int t = 0; t < T2; t++) s += longint'(sample2[t]) * longint'(coef2[k*T2 + t]);
            exp2[k] = ACC_W'(s);
        end
    endtask

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int               exp_idx = 0, done_cnt = 0, clr_cnt = 0, stall_model = 0;
    bit               done_exp = 1'b0, prev_hold = 1'b0;
    logic [ACC_W-1:0] prev_data = '0;
    logic [IDX_W-1:0] prev_idx = '0;

    // Per-cycle compare process (inputs are stable from posedge+1 to next posedge)
    always @(negedge clk) begin
        if (!rst) begin
            exp_idx   = 0;
            done_exp  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("done_pulse", longint'(done), longint'(done_exp));
            if (done) done_cnt++;
            if (!ena) chk("mac_en_while_frozen", longint'(mac_en), 0);
            if (mac_clr) begin
                clr_cnt++;
                chk("mac_clr_tap", longint'(sample_sel), 0);
            end
            if (res_valid) begin
                chk("res_idx", longint'(res_idx), longint'(exp_idx));
                chk("res_data", longint'(res_data), longint'(exp_data[res_idx]));
                chk("mac_en_in_hold", longint'(mac_en), 0);
                if (prev_hold) begin
                    chk("hold_data_stable", longint'(res_data), longint'(prev_data));
                    chk("hold_idx_stable", longint'(res_idx), longint'(prev_idx));
                end
            end
            done_exp  = ena && res_valid && res_ready && (res_idx == IDX_W'(OUTS - 1));
            if (ena && res_valid && !res_ready) stall_model++;
            prev_hold = res_valid && !(ena && res_ready);
            prev_data = res_data;
            prev_idx  = res_idx;
            if (ena && res_valid && res_ready) exp_idx = (exp_idx + 1) % OUTS;
        end
    end

    // One full pass with optional stall, freeze, busy starts or random ena/ready
    task automatic run_pass(input bit det, input int stall_idx, input bit freeze,
                            input bit busy_starts, input bit rnd, input int exp_lat);
        int cyc, d0;
        bit stalled, frozen, s_hold, s_acc;
        logic [ACC_W-1:0] d;
        stalled = 0; frozen = 0; s_hold = 0; s_acc = 0;
        new_data(det);
        clr_cnt = 0; stall_model = 0; d0 = done_cnt;
        ena = 1'b1; res_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        chk("first_mac_en", longint'(mac_en), 1);
        chk("first_tap", longint'(sample_sel), 0);
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (rnd) begin
                ena       = ($urandom % 8) != 0;
                res_ready = ($urandom % 4) != 0;
            end
            if (freeze && !frozen && busy && !res_valid && sample_sel == 3'd4) begin
                frozen = 1; ena = 1'b0;
                repeat (3) begin
                    tick(); cyc++;
                    chk("freeze_tap", longint'(sample_sel), 4);
                    chk("freeze_mac_en", longint'(mac_en), 0);
                end
                ena = 1'b1;
                #1;
                chk("resume_tap", longint'(sample_sel), 4);
                chk("resume_mac_en", longint'(mac_en), 1);
            end
            if (stall_idx >= 0 && !stalled && res_valid && res_idx == IDX_W'(stall_idx)) begin
                stalled = 1; res_ready = 1'b0; d = res_data;
                repeat (5) begin
                    tick(); cyc++;
                    chk("stall_data", longint'(res_data), longint'(d));
                    chk("stall_idx", longint'(res_idx), longint'(stall_idx));
                    chk("stall_valid", longint'(res_valid), 1);
                end
                res_ready = 1'b1;
            end
            start = 1'b0;
            if (busy_starts && !s_hold && res_valid && res_idx == 3'd1) begin
                s_hold = 1; start = 1'b1;
            end else if (busy_starts && s_hold && !s_acc && sample_sel == 3'd2) begin
                s_acc = 1; start = 1'b1;
            end
            tick(); cyc++;
        end
        start = 1'b0; ena = 1'b1; res_ready = 1'b1;
        chk("done_seen", longint'(done), 1);
        if (exp_lat > 0) chk("done_latency", cyc, exp_lat);
        if (busy_starts) chk("busy_starts_issued", longint'(s_hold && s_acc), 1);
        chk("mac_clr_count", clr_cnt, OUTS);
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
        chk("stall_cnt_model", longint'(stall_cnt), stall_model);
        if (stall_idx >= 0) chk("stall_cnt_literal", longint'(stall_cnt), 5);
`endif
        tick();
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after_done", longint'(busy), 0);
    endtask

    task automatic reset_mid_pass();
        int n, d0;
        new_data(0);
        ena = 1'b1; res_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(res_valid && res_idx == 3'd5) && n < 500) begin tick(); n++; end
        chk("reach_coef5", longint'(res_valid && res_idx == 3'd5), 1);
        tick();
        chk("coef6_addr", longint'(coef_sel), 48);
        repeat (8) tick();
        chk("drain_busy", longint'(busy), 1);
        chk("drain_no_valid", longint'(res_valid), 0);
        chk("drain_tap_wrap", longint'(sample_sel), 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_valid", longint'(res_valid), 0);
        chk("rst_data", longint'(res_data), 0);
        chk("rst_idx", longint'(res_idx), 0);
        d0 = done_cnt;
        repeat (4) tick();
        chk("no_done_after_rst", done_cnt - d0, 0);
    endtask

    task automatic run_small();
        int cyc, last, nres;
        new_data2();
        chk("model_pin_small", longint'(exp2[3]), 40);
        ena = 1'b1; res_ready = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("small_first_mac_en", longint'(mac_en2), 1);
        cyc = 0; last = 0; nres = 0;
        while (!done2 && cyc < 500) begin
            if (res_valid2) begin
                chk("small_idx", longint'(res_idx2), nres);
                chk("small_data", longint'(res_data2), longint'(exp2[res_idx2]));
                if (nres > 0) chk("small_spacing", cyc - last, 6);
                last = cyc; nres++;
            end
            tick(); cyc++;
        end
        chk("small_done_latency", cyc, 24);
        chk("small_result_count", nres, 4);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_busy0", longint'(busy), 0);
        chk("rst_done0", longint'(done), 0);
        chk("rst_valid0", longint'(res_valid), 0);
        chk("rst_data0", longint'(res_data), 0);
        chk("rst_idx0", longint'(res_idx), 0);
        chk("rst_mac_en0", longint'(mac_en), 0);
        chk("rst_mac_clr0", longint'(mac_clr), 0);
        chk("rst_coef_sel0", longint'(coef_sel), 0);
        chk("rst_busy2", longint'(busy2), 0);
`ifdef DCT_MAC_SEQ_STALL_CNT_EN
        chk("rst_stall_cnt", longint'(stall_cnt), 0);
`endif
        rst = 1'b1;
        tick();

        new_data(1);
        chk("model_pin_k3", longint'(exp_data[3]), 108);
        chk("model_pin_k7", longint'(exp_data[7]), 252);

        run_pass(1, -1, 0, 0, 0, 88);   // basic
        run_pass(0,  3, 0, 0, 0, 93);   // backpressure on coefficient 3
        run_pass(0, -1, 1, 0, 0, 91);   // ena freeze at tap 4
        run_pass(0, -1, 0, 1, 0, 88);   // starts while busy
        run_pass(0, -1, 0, 0, 0, 88);   // start in the cycle after done
        reset_mid_pass();
        run_pass(0, -1, 0, 0, 0, 88);   // clean pass after reset
        repeat (3) run_pass(0, -1, 0, 0, 1, 0);
        run_small();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
